imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction fetch sequencer that drives the address of the asynchronous 64-word instruction ROM and presents fetched words to decode. It holds the fetch PC and a 2-entry instruction buffer with a valid/ready handshake to decode. It also handles branch redirects, halts and out-of-range fetch faults. It sits between the instruction memory and the decode stage of the pipelined core.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.
- `MEM_WORDS`, default 64: number of valid instruction words; word index `pc[31:2]` must be < `MEM_WORDS`.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  32  byte address to instruction memory; equals the `fetch_pc` register.
- `imem_instr`  in  32  instruction word, combinational from `imem_addr`.
- `redirect_valid`  in  1  taken branch or jump from execute; one-cycle pulse or level.
- `redirect_pc`  in  32  redirect target byte address.
- `halt`  in  1  level; while high, no new fetches are issued.
- `out_valid`  out  1  buffer head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction word.
- `out_pc`  out  32  byte address of the head instruction.
- `fault`  out  1  sticky fetch fault: misaligned or out-of-range PC.

## Operation
- State: `fetch_pc` (32), 2-slot FIFO of {pc, instr}, `count` (0..2), FSM state in {RUN, HALT, FAULT}.
- Pop: occurs when `out_valid && out_ready`.
- Push condition: state RUN, `halt`=0, PC good, and (`count`<2 or pop this cycle).
  - Push writes {`fetch_pc`, `imem_instr`} to the tail and increments `fetch_pc` by 4, mod 2^32.
- PC good: `fetch_pc[1:0]`==0 and `fetch_pc[31:2]` < `MEM_WORDS`.
  - If the FSM would push but the PC is not good, there is no push, `fault`<=1 and the state becomes FAULT.
  - `fetch_pc` holds the bad value, visible on `imem_addr`.
- FSM transitions, priority high to low:
  - Redirect from any state: flush FIFO (`count`<=0), `fetch_pc`<=`redirect_pc`, `fault`<=0, next state RUN if `halt`=0, else HALT. No push in the redirect cycle.
  - FAULT: holds until redirect or reset. Buffered entries still drain to decode.
  - RUN→HALT when `halt`=1. HALT→RUN when `halt`=0. The halt-release cycle itself may push.
  - RUN→FAULT on bad-PC fetch attempt, as above.
- Simultaneous push and pop with `count`=2 or 1: `count` unchanged, FIFO order preserved.
- Simultaneous push and pop with `count`=0: not possible; pop requires `out_valid`.
- Pop coincident with redirect: the handshake is complete (decode consumed the head), then the flush clears all remaining entries.
- `out_instr`/`out_pc` reflect the head slot. Their values are unchecked while `out_valid`=0.

## Timing
- Reset (async assert) values:
  - `fetch_pc`=`RESET_PC`, so `imem_addr`=`RESET_PC`.
  - `count`=0, `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0, state RUN.
- Reset release: first push at the first rising edge with `rst_n`=1. `out_valid`=1 after that edge.
- Throughput: 1 instruction per cycle with `out_ready` held high.
- Fetch-to-decode latency: 1 edge.
- Redirect sampled at edge k:
  - `out_valid`=0 and `imem_addr`=target after edge k.
  - Target instruction pushed at edge k+1, visible after edge k+1.
  - Redirect penalty: 1 empty cycle.
- `out_ready`=0 with `count`=2: no push, and `fetch_pc` and `imem_addr` hold.
- `fault` rises the edge after the bad-PC attempt. It falls the edge after a redirect.
- `out_valid` depends only on registers, never combinationally on `out_ready`.
- `imem_addr` is register-driven and has no combinational path from any input.

## Test plan
- Reset then run, `out_ready`=1, ROM word i = i: after edges 1..5, `out_pc`=0,4,8,12,16 and `out_instr`=0..4; `out_valid` stays 1.
- Backpressure: `out_ready`=0 for 4 cycles after reset → `count` saturates at 2 and `imem_addr` holds 8. On release, `out_pc` sequence is 0, 4, 8, with no loss or duplicate.
- Redirect with `redirect_pc`=0x40 while `count`=2 and pop active → the popped entry is consumed once, `out_valid`=0 next cycle, then `out_pc`=0x40.
- Out-of-range: run to `fetch_pc`=0xFC then 0x100 → the word at 0xFC is delivered, then `fault`=1 and no further pushes. A redirect to 0x10 clears `fault` and resumes at 0x10.
- Misaligned redirect to 0x22 → `fault`=1 after the next edge, `out_valid`=0, and `imem_addr`=0x22 holds.
- Halt asserted for 3 cycles mid-stream → buffered entries drain and no new pushes occur. Fetch resumes at the held PC on the release cycle. An async `rst_n` pulse mid-stream clears `out_valid` immediately and restarts at `RESET_PC`.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// rtl/imem_fetch_ctrl.sv - instruction fetch sequencer with a 2-entry buffer to decode
// Drives the ROM address from the fetch PC and handles redirect, halt and bad-PC faults.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_pc0, r_pc1;
  logic [31:0] r_instr0, r_instr1;
  logic [1:0]  r_count;
  logic        r_fault;

  logic w_pop;
  logic w_pc_good;
  logic w_try;
  logic w_push;
  logic w_bad;

  assign w_pop     = (r_count != 2'd0) && out_ready;
  assign w_pc_good = (r_fetch_pc[1:0] == 2'b00) &&
                     ({2'b00, r_fetch_pc[31:2]} < 32'(MEM_WORDS));
  // A fetch is attempted from RUN or on the halt-release cycle, never during redirect.
  assign w_try  = (r_state != S_FAULT) && !halt && !redirect_valid &&
                  ((r_count != 2'd2) || w_pop);
  assign w_push = w_try && w_pc_good;
  assign w_bad  = w_try && !w_pc_good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      w_state_nxt = halt ? S_HALT : S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (halt) w_state_nxt = S_HALT;
                 else if (w_bad) w_state_nxt = S_FAULT;
        S_HALT:  if (!halt) w_state_nxt = w_bad ? S_FAULT : S_RUN;
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_RUN;
      endcase
    end
  end

  always_comb begin
    imem_addr = r_fetch_pc;
    out_valid = (r_count != 2'd0);
    out_pc    = r_pc0;
    out_instr = r_instr0;
    fault     = r_fault;
  end

  // Slot 0 is always the head; slot 1 shifts down on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_count    <= 2'd0;
      r_fault    <= 1'b0;
      r_pc0      <= 32'd0;
      r_pc1      <= 32'd0;
      r_instr0   <= 32'd0;
      r_instr1   <= 32'd0;
    end else if (redirect_valid) begin
      r_count    <= 2'd0;
      r_fetch_pc <= redirect_pc;
      r_fault    <= 1'b0;
    end else begin
      if (w_bad) r_fault <= 1'b1;
      if (w_push) r_fetch_pc <= r_fetch_pc + 32'd4;
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd1) begin
            r_pc0    <= r_fetch_pc;
            r_instr0 <= imem_instr;
          end else begin
            r_pc0    <= r_pc1;
            r_instr0 <= r_instr1;
            r_pc1    <= r_fetch_pc;
            r_instr1 <= imem_instr;
          end
        end
        2'b01: begin
          r_pc0    <= r_pc1;
          r_instr0 <= r_instr1;
          r_count  <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_pc0    <= r_fetch_pc;
            r_instr0 <= imem_instr;
          end else begin
            r_pc1    <= r_fetch_pc;
            r_instr1 <= imem_instr;
          end
          r_count <= r_count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
